data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 72 +++++++
 tb/tb_data_memory.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed data memory with a self-clearing sequence after reset or on
// request, a single CPU load/store port and a lower-priority preload port.
module data_memory #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] dmem_addr,
  input  logic                 dmem_w_en,
  input  logic [WIDTH-1:0]     dmem_wdata,
  output logic [WIDTH-1:0]     dmem_rdata,
  output logic                 ready,
  input  logic                 clear_req,
  input  logic                 pl_valid,
  output logic                 pl_ready,
  input  logic [ADDR_BITS-1:0] pl_addr,
  input  logic [WIDTH-1:0]     pl_data
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] clr_cnt;
  logic [WIDTH-1:0]     mem [DEPTH];

  // CPU port wins over preload; clear requests block both.
  assign pl_ready   = (state == READY) && !clear_req && !dmem_w_en;
  assign dmem_rdata = (state == READY) ? mem[dmem_addr] : '0;

  // Array writes live under the async reset so nothing is written while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          mem[clr_cnt] <= '0;
          clr_cnt      <= clr_cnt + ADDR_BITS'(1);
          if (clr_cnt == ADDR_BITS'(DEPTH - 1)) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end else if (dmem_w_en) begin
            mem[dmem_addr] <= dmem_wdata;
          end else if (pl_valid && pl_ready) begin
            mem[pl_addr] <= pl_data;
          end
        end
        default: begin
          state <= CLEAR;
          clr_cnt <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory: clear timing, CPU store
// visibility, preload arbitration, clear requests and reset restarts.
module tb_data_memory;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADDR_BITS = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [ADDR_BITS-1:0] dmem_addr;
  logic                 dmem_w_en;
  logic [WIDTH-1:0]     dmem_wdata;
  logic [WIDTH-1:0]     dmem_rdata;
  logic                 ready;
  logic                 clear_req;
  logic                 pl_valid;
  logic                 pl_ready;
  logic [ADDR_BITS-1:0] pl_addr;
  logic [WIDTH-1:0]     pl_data;

  int checks   = 0;
  int failures = 0;

  data_memory #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .dmem_addr  (dmem_addr),
    .dmem_w_en  (dmem_w_en),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .ready      (ready),
    .clear_req  (clear_req),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .pl_addr    (pl_addr),
    .pl_data    (pl_data)
  );

  always #5 clk = ~clk;

  // Advance to 1ns past the next rising edge, where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises (bounded); returns the edge count or -1.
  task automatic count_to_ready(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; dmem_addr = '0; dmem_w_en = 1'b0; dmem_wdata = '0;
    clear_req = 1'b0; pl_valid = 1'b1; pl_addr = '0; pl_data = '0;
    #2;
    step(); step();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if (pl_ready !== 1'b0) begin failures++; $display("FAIL reset_pl_ready got=%b exp=0", pl_ready); end
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", dmem_rdata); end
    pl_valid = 1'b0;
    reset = 1'b0;
    count_to_ready(n);
    checks++;
    if (n != 64) begin failures++; $display("FAIL reset_clear_edges got=%0d exp=64", n); end
    for (int a = 0; a < 64; a++) begin
      dmem_addr = ADDR_BITS'(a);
      #1;
      checks++;
      if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL zero_after_clear addr=%0d got=%h exp=0", a, dmem_rdata); end
    end
  endtask

  task automatic test_store();
    dmem_addr = 6'd5; dmem_w_en = 1'b1; dmem_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL store_same_cycle got=%h exp=0", dmem_rdata); end
    step();
    dmem_w_en = 1'b0;
    #1;
    checks++;
    if (dmem_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL store_next_cycle got=%h exp=deadbeef", dmem_rdata); end
  endtask

  task automatic test_preload_priority();
    pl_valid = 1'b1; pl_addr = 6'd63; pl_data = 32'h12345678;
    for (int c = 0; c < 3; c++) begin
      dmem_w_en = 1'b1; dmem_addr = ADDR_BITS'(10 + c); dmem_wdata = 32'h100 + 32'(c);
      #1;
      checks++;
      if (pl_ready !== 1'b0) begin failures++; $display("FAIL pl_blocked cycle=%0d got=%b exp=0", c, pl_ready); end
      step();
    end
    dmem_w_en = 1'b0;
    dmem_addr = 6'd63;
    #1;
    checks++;
    if (pl_ready !== 1'b1) begin failures++; $display("FAIL pl_accept got=%b exp=1", pl_ready); end
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL pl_not_early got=%h exp=0", dmem_rdata); end
    step();
    pl_valid = 1'b0;
    #1;
    checks++;
    if (dmem_rdata !== 32'h12345678) begin failures++; $display("FAIL pl_commit got=%h exp=12345678", dmem_rdata); end
    for (int c = 0; c < 3; c++) begin
      dmem_addr = ADDR_BITS'(10 + c);
      #1;
      checks++;
      if (dmem_rdata !== 32'h100 + 32'(c)) begin
        failures++; $display("FAIL cpu_store_during_pl addr=%0d got=%h exp=%h", 10 + c, dmem_rdata, 32'h100 + 32'(c));
      end
    end
  endtask

  task automatic test_clear_req();
    int n;
    clear_req = 1'b1; dmem_w_en = 1'b1; dmem_addr = 6'd7; dmem_wdata = 32'hAAAA5555;
    pl_valid = 1'b1; pl_addr = 6'd8; pl_data = 32'h0BADF00D;
    #1;
    checks++;
    if (pl_ready !== 1'b0) begin failures++; $display("FAIL clr_pl_ready got=%b exp=0", pl_ready); end
    step();
    clear_req = 1'b0; dmem_w_en = 1'b0; pl_valid = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL clr_ready_drop got=%b exp=0", ready); end
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clr_rdata got=%h exp=0", dmem_rdata); end
    // A second request mid-clear must neither restart nor extend the sequence.
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      clear_req = (i == 10);
      if (ready === 1'b1) begin n = i; break; end
    end
    clear_req = 1'b0;
    checks++;
    if (n != 64) begin failures++; $display("FAIL clr_edges got=%0d exp=64", n); end
    dmem_addr = 6'd7; #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clr_addr7 got=%h exp=0", dmem_rdata); end
    dmem_addr = 6'd5; #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clr_addr5 got=%h exp=0", dmem_rdata); end
    dmem_addr = 6'd63; #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clr_addr63 got=%h exp=0", dmem_rdata); end
  endtask

  task automatic test_reset_restart();
    int n;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i < 30; i++) step();
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rst_mid_clear_ready got=%b exp=0", ready); end
    step(); step();
    reset = 1'b0;
    count_to_ready(n);
    checks++;
    if (n != 64) begin failures++; $display("FAIL rst_mid_clear_edges got=%0d exp=64", n); end
    // Asynchronous reset from READY, observed before any clock edge.
    dmem_addr = 6'd3; dmem_w_en = 1'b1; dmem_wdata = 32'h55;
    step();
    dmem_w_en = 1'b0;
    #1;
    checks++;
    if (dmem_rdata !== 32'h55) begin failures++; $display("FAIL rst_pre_store got=%h exp=55", dmem_rdata); end
    reset = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready_ready got=%b exp=0", ready); end
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_ready_rdata got=%h exp=0", dmem_rdata); end
    step(); step();
    reset = 1'b0;
    count_to_ready(n);
    checks++;
    if (n != 64) begin failures++; $display("FAIL rst_mid_ready_edges got=%0d exp=64", n); end
  endtask

  task automatic test_clear_ignores_writes();
    int n;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    dmem_w_en = 1'b1; dmem_addr = 6'd0; dmem_wdata = 32'hFFFFFFFF;
    pl_valid = 1'b1; pl_addr = 6'd1; pl_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clear_cpu_rdata got=%h exp=0", dmem_rdata); end
    checks++;
    if (pl_ready !== 1'b0) begin failures++; $display("FAIL clear_pl_ready got=%b exp=0", pl_ready); end
    // Keep writing until just before the final clear edge, then release.
    n = -1;
    for (int i = 2; i <= 200; i++) begin
      step();
      if (i == 63) begin dmem_w_en = 1'b0; pl_valid = 1'b0; end
      if (ready === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 64) begin failures++; $display("FAIL clear_cpu_edges got=%0d exp=64", n); end
    dmem_addr = 6'd0; #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clear_cpu_addr0 got=%h exp=0", dmem_rdata); end
    dmem_addr = 6'd1; #1;
    checks++;
    if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL clear_pl_addr1 got=%h exp=0", dmem_rdata); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_preload_priority();
    test_clear_req();
    test_reset_restart();
    test_clear_ignores_writes();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
